// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN (see serial_adder.sv).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: it must hold the values 0 .. WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder. Purely combinational.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: sum = a + b + cin, one bit per clock, LSB first.
// Operands are loaded in parallel when start is accepted in IDLE. done pulses
// for one cycle when sum/cout become valid. sum and cout hold between results.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed
// overflow flag (ovf) that is updated together with sum/cout.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;
  logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign last_bit = (cnt_q == LAST);

  full_adder_cell u_fa (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start is only looked at in IDLE; DONE always returns.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_d unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: busy only in RUN, done only in DONE, never together.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next-state: load on accept, shift one bit per RUN cycle,
  // publish sum/cout only on the last RUN edge.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d  = {fa_s, res_q[WIDTH-1:1]};
          cout_d = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on the last bit.
          ovf_d  = carry_q ^ fa_co;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed 8-bit vectors with
// hand-computed results, handshake/latency checks, start-while-busy, reset
// mid-operation, and an exhaustive sweep of a 4-bit instance.
// Define SERIAL_ADDER_OVF_EN for both RTL and bench to check ovf.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  // 8-bit instance
  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8;
  logic       ovf4;
`endif

  // 4-bit instance
  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf8),
`endif
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf4),
`endif
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One 8-bit operation. Watches WIDTH+3 cycles after the accept edge and
  // records latency, busy/done counts, overlap and early sum changes.
  logic r_ovf;
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                     output logic [7:0] osum, output logic ocout,
                     output int lat, output int nbusy, output int ndone, output int nglitch);
    logic [7:0] prev_sum;
    lat = 0; nbusy = 0; ndone = 0; nglitch = 0;
    osum = 'x; ocout = 1'bx; r_ovf = 1'bx;
    @(negedge clk);
    prev_sum = sum8;
    a8 = ia; b8 = ib; cin8 = icin; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (busy8 && done8) nglitch++;
      if (ndone == 0 && !done8 && sum8 !== prev_sum) nglitch++;
      if (done8) begin
        ndone++;
        if (lat == 0) begin
          lat = n; osum = sum8; ocout = cout8;
`ifdef SERIAL_ADDER_OVF_EN
          r_ovf = ovf8;
`endif
        end
      end
    end
    if (sum8 !== osum) nglitch++;
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic icin,
                     output logic [4:0] ores, output int ndone);
    ndone = 0; ores = 'x;
    @(negedge clk);
    a4 = ia; b4 = ib; cin4 = icin; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (done4) begin
        ndone++;
        ores = {cout4, sum4};
      end
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    logic       c;
    logic [4:0] r4;
    int lat, nb, nd, ng;

    vecs[0] = '{8'd3,   8'd5,   1'b0, 8'd8,   1'b0};
    vecs[1] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1};
    vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd1,   1'b0};
    vecs[3] = '{8'd170, 8'd85,  1'b1, 8'd0,   1'b1};
    vecs[4] = '{8'd200, 8'd55,  1'b0, 8'd255, 1'b0};
    vecs[5] = '{8'd100, 8'd100, 1'b1, 8'd201, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_sum",  sum8, 8'd0);
    check("rst_cout", cout8, 1'b0);
    rst_n = 1'b1;

    // Directed vectors; full handshake checks on every one.
    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat, nb, nd, ng);
      check($sformatf("v%0d_sum", i), s, vecs[i].s);
      check($sformatf("v%0d_cout", i), c, vecs[i].c);
      check($sformatf("v%0d_latency", i), lat, 9);
      check($sformatf("v%0d_busy_cycles", i), nb, 8);
      check($sformatf("v%0d_done_pulses", i), nd, 1);
      check($sformatf("v%0d_glitch", i), ng, 0);
    end

    // start held high through RUN and DONE with different operands.
    begin
      int nd1, nb1;
      logic [7:0] s1;
      nd1 = 0; nb1 = 0; s1 = 'x;
      @(negedge clk);
      a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1;
      a8 = 8'd99; b8 = 8'd99;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (busy8) nb1++;
        if (done8) begin nd1++; s1 = sum8; end
        if (n == 9) check("hold_done_c9", done8, 1'b1);
        if (n == 10) check("hold_idle_c10_busy", busy8, 1'b0);
      end
      check("hold_sum", s1, 8'd30);
      check("hold_busy_cycles", nb1, 8);
      check("hold_done_pulses", nd1, 1);
      // IDLE sampled start at the end of cycle 10: second op 99+99.
      nd1 = 0; s1 = 'x;
      for (int n = 11; n <= 22; n++) begin
        @(negedge clk);
        if (n == 11) begin
          start8 = 1'b0;
          check("hold_second_busy", busy8, 1'b1);
        end
        if (done8) begin nd1++; s1 = sum8; end
        if (n == 19) check("hold_second_done_c19", done8, 1'b1);
      end
      check("hold_second_sum", s1, 8'd198);
      check("hold_second_pulses", nd1, 1);
    end

    // Reset in RUN cycle 4.
    begin
      int nd2;
      nd2 = 0;
      @(negedge clk);
      a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      for (int n = 1; n <= 4; n++) @(negedge clk);
      check("rstmid_busy_before", busy8, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_busy", busy8, 1'b0);
      check("rstmid_done", done8, 1'b0);
      check("rstmid_sum", sum8, 8'd0);
      check("rstmid_cout", cout8, 1'b0);
      rst_n = 1'b1;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (done8) nd2++;
      end
      check("rstmid_no_done", nd2, 0);
      op8(8'd7, 8'd8, 1'b0, s, c, lat, nb, nd, ng);
      check("after_rst_sum", s, 8'd15);
      check("after_rst_cout", c, 1'b0);
      check("after_rst_done", nd, 1);
    end

`ifdef SERIAL_ADDER_OVF_EN
    op8(8'd127, 8'd1, 1'b0, s, c, lat, nb, nd, ng);
    check("ovf1_sum", s, 8'd128);
    check("ovf1_cout", c, 1'b0);
    check("ovf1_ovf", r_ovf, 1'b1);
    op8(8'd255, 8'd1, 1'b0, s, c, lat, nb, nd, ng);
    check("ovf2_sum", s, 8'd0);
    check("ovf2_cout", c, 1'b1);
    check("ovf2_ovf", r_ovf, 1'b0);
    op8(8'd128, 8'd128, 1'b0, s, c, lat, nb, nd, ng);
    check("ovf3_sum", s, 8'd0);
    check("ovf3_cout", c, 1'b1);
    check("ovf3_ovf", r_ovf, 1'b1);
`endif

    // Exhaustive 4-bit sweep against integer addition.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          op4(4'(ia), 4'(ib), 1'(ic), r4, nd);
          check($sformatf("exh_%0d_%0d_%0d", ia, ib, ic), r4, 32'(ia + ib + ic));
          check($sformatf("exh_done_%0d_%0d_%0d", ia, ib, ic), nd, 1);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_adder
